ula_seq: RTL and testbench
==========================

ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port input_a, input, WIDTH, operand A.
REQ-005 Port input_b, input, WIDTH, operand B; also the shift amount for shift ops.
REQ-006 Port sel, input, 3, operation select.
REQ-007 Port in_valid, input, 1, operation request.
REQ-008 Port in_ready, output, 1, block can accept a request.
REQ-009 Port output_s, output, WIDTH, registered result.
REQ-010 Port flags, output, 4, registered {carry, overflow, negative, zero}.
REQ-011 Port out_valid, output, 1, output_s/flags hold a result.
REQ-012 Port out_ready, input, 1, consumer accepts result.

Function
REQ-013 sel encoding SHALL be: 000 add, 001 sub (A-B), 010 logical shift right A by B, 011 logical shift left A by B, 100 AND, 101 OR, 110 XOR, 111 unsigned multiply.
REQ-014 FSM SHALL have states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept SHALL occur on a clock edge with in_valid=1 and in_ready=1; input_a, input_b and sel SHALL be captured at accept and later input changes ignored.
REQ-016 Ops 000-110 SHALL go IDLE->DONE at accept; result and out_valid=1 visible the cycle after accept (latency 1).
REQ-017 Multiply SHALL go IDLE->CALC at accept, run WIDTH shift-add iterations (one per cycle), then ->DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-018 DONE SHALL hold output_s, flags and out_valid=1 stable until an edge with out_ready=1, then go to IDLE with out_valid=0.
REQ-019 in_valid SHALL be ignored in CALC and DONE; no request is queued.
REQ-020 Add/sub results SHALL wrap modulo 2^WIDTH.
REQ-021 carry: add = carry out of MSB; sub = borrow (A<B unsigned); multiply = 1 if upper WIDTH bits of the 2*WIDTH product are nonzero; other ops = 0.
REQ-022 overflow: two's-complement signed overflow for add/sub; 0 for all other ops.
REQ-023 negative SHALL equal output_s[WIDTH-1]; zero SHALL be 1 iff output_s==0; both valid for every op.
REQ-024 Shift amount >= WIDTH SHALL give output_s=0; shift by 0 SHALL give A.
REQ-025 Multiply output_s SHALL be the low WIDTH bits of the unsigned product.
REQ-026 output_s and flags SHALL change only on entry to DONE.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, output_s=0, flags=0, out_valid=0, multiply iteration counter and partial product 0.
REQ-028 in_ready SHALL be 0 while rst_n=0 and 1 from the first edge after release.
REQ-029 Reset during CALC or DONE SHALL discard the operation; no out_valid SHALL follow.

Verification (WIDTH=4)
REQ-030 Add 3+1, out_ready=1 -> next cycle out_valid=1, output_s=4, flags=0000; following cycle in_ready=1.
REQ-031 Add 15+2 -> output_s=1, carry=1, overflow=0, zero=0; sub 7-8 -> output_s=15, carry=1, overflow=1, negative=1.
REQ-032 Shifts: 4>>1 -> 2; 2>>2 -> 0 with zero=1; 15>>4 -> 0; 1<<1 -> 2; 1<<5 -> 0.
REQ-033 Multiply 5*3 -> out_valid exactly 5 cycles after accept, output_s=15, carry=0; 6*5 -> output_s=14, carry=1; in_valid pulses during CALC produce no extra result.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while toggling inputs -> output_s/flags/out_valid unchanged, in_ready=0; release -> IDLE next edge.
REQ-035 Assert rst_n=0 mid-multiply between edges -> out_valid=0, output_s=0 immediately; after release no result appears and in_ready=1.

Source files
------------

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle add/sub/shift/logic ops and a
// shift-add unsigned multiply, with valid/ready handshakes on both sides.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [2:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] output_s,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic                 shamt_big;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 accept;

    assign accept    = in_valid && in_ready;
    assign sum       = {1'b0, input_a} + {1'b0, input_b};
    assign diff      = {1'b0, input_a} - {1'b0, input_b};
    assign shamt_big = 32'(input_b) >= 32'(WIDTH);
    assign mcand     = {{WIDTH{1'b0}}, op_a} << cnt;
    assign acc_next  = acc + (op_b[cnt] ? mcand : '0);

    // Single-cycle datapath, evaluated on the live inputs at accept time.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (sel)
            3'b000: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != input_a[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != input_a[WIDTH-1]);
            end
            3'b010:  alu_res = shamt_big ? '0 : (input_a >> input_b);
            3'b011:  alu_res = shamt_big ? '0 : (input_a << input_b);
            3'b100:  alu_res = input_a & input_b;
            3'b101:  alu_res = input_a | input_b;
            3'b110:  alu_res = input_a ^ input_b;
            3'b111:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            output_s  <= '0;
            flags     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        op_a     <= input_a;
                        op_b     <= input_b;
                        if (sel == 3'b111) begin
                            state <= CALC;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            output_s  <= alu_res;
                            flags     <= {alu_c, alu_v, alu_res[WIDTH-1],
                                          alu_res == '0};
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        output_s  <= acc_next[WIDTH-1:0];
                        flags     <= {|acc_next[2*WIDTH-1:WIDTH], 1'b0,
                                      acc_next[WIDTH-1],
                                      acc_next[WIDTH-1:0] == '0};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq at WIDTH=4.
// Hand-computed vectors cover every op, handshake and reset cases.
module tb_ula_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic [2:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] output_s;
    logic [3:0]   flags;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;
    int lat;
    int seen_ov;

    ula_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_a   (input_a),
        .input_b   (input_b),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .output_s  (output_s),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one single-cycle op, check its result, then drain it.
    task automatic alu_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] s,
                          input logic [W-1:0] es, input logic [3:0] ef);
        input_a  = a;
        input_b  = b;
        sel      = s;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"}, 32'(output_s), 32'(es));
        chk({tag, "_f"}, 32'(flags), 32'(ef));
        tick;
    endtask

    // Accept a multiply, pulse in_valid during CALC, measure latency.
    task automatic mul_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] es,
                          input logic [3:0] ef);
        input_a  = a;
        input_b  = b;
        sel      = 3'b111;
        in_valid = 1'b1;
        tick;
        lat      = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            in_valid = (lat == 1 || lat == 2);
            sel      = 3'b000;
            input_a  = 4'd1;
            input_b  = 4'd1;
            tick;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_s"}, 32'(output_s), 32'(es));
        chk({tag, "_f"}, 32'(flags), 32'(ef));
        tick;
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
        tick;
        chk({tag, "_noextra"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b1;
        input_a   = '0;
        input_b   = '0;
        sel       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(output_s), 32'd0);
        chk("rst_f", 32'(flags), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        tick;
        tick;
        chk("rst_rdy_hold", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick;
        chk("rel_rdy", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        input_a   = 4'd3;
        input_b   = 4'd1;
        sel       = 3'b000;
        in_valid  = 1'b1;
        tick;
        in_valid  = 1'b0;
        chk("add31_ov", 32'(out_valid), 32'd1);
        chk("add31_s", 32'(output_s), 32'd4);
        chk("add31_f", 32'(flags), 32'b0000);
        chk("add31_busy", 32'(in_ready), 32'd0);
        tick;
        chk("add31_drain", 32'(out_valid), 32'd0);
        chk("add31_rdy", 32'(in_ready), 32'd1);

        alu_op("add15_2", 4'd15, 4'd2, 3'b000, 4'd1, 4'b1000);
        alu_op("add4_4", 4'd4, 4'd4, 3'b000, 4'd8, 4'b0110);
        alu_op("sub7_8", 4'd7, 4'd8, 3'b001, 4'd15, 4'b1110);
        alu_op("sub5_5", 4'd5, 4'd5, 3'b001, 4'd0, 4'b0001);
        alu_op("srl4_1", 4'd4, 4'd1, 3'b010, 4'd2, 4'b0000);
        alu_op("srl2_2", 4'd2, 4'd2, 3'b010, 4'd0, 4'b0001);
        alu_op("srl15_4", 4'd15, 4'd4, 3'b010, 4'd0, 4'b0001);
        alu_op("srl9_0", 4'd9, 4'd0, 3'b010, 4'd9, 4'b0010);
        alu_op("sll1_1", 4'd1, 4'd1, 3'b011, 4'd2, 4'b0000);
        alu_op("sll1_5", 4'd1, 4'd5, 3'b011, 4'd0, 4'b0001);
        alu_op("and", 4'd12, 4'd10, 3'b100, 4'd8, 4'b0010);
        alu_op("or", 4'd12, 4'd3, 3'b101, 4'd15, 4'b0010);
        alu_op("xor", 4'd5, 4'd5, 3'b110, 4'd0, 4'b0001);

        mul_op("mul5_3", 4'd5, 4'd3, 4'd15, 4'b0010);
        mul_op("mul6_5", 4'd6, 4'd5, 4'd14, 4'b1010);

        out_ready = 1'b0;
        input_a   = 4'd2;
        input_b   = 4'd3;
        sel       = 3'b000;
        in_valid  = 1'b1;
        tick;
        chk("hold_ov0", 32'(out_valid), 32'd1);
        chk("hold_s0", 32'(output_s), 32'd5);
        for (int i = 0; i < 3; i++) begin
            input_a  = 4'(i + 9);
            input_b  = 4'(i + 6);
            sel      = 3'(i + 1);
            in_valid = i[0];
            tick;
            chk("hold_ov", 32'(out_valid), 32'd1);
            chk("hold_s", 32'(output_s), 32'd5);
            chk("hold_f", 32'(flags), 32'b0000);
            chk("hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("hold_rel_ov", 32'(out_valid), 32'd0);
        chk("hold_rel_rdy", 32'(in_ready), 32'd1);

        input_a  = 4'd7;
        input_b  = 4'd7;
        sel      = 3'b111;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ov", 32'(out_valid), 32'd0);
        chk("mrst_s", 32'(output_s), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd0);
        tick;
        rst_n   = 1'b1;
        seen_ov = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (out_valid) seen_ov++;
        end
        chk("mrst_noresult", 32'(seen_ov), 32'd0);
        chk("mrst_rdy1", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
